// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin share of one sprite ROM read port among four ghost renderers, with ID-tagged responses
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 64,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  output logic [N_REQ-1:0]          gnt,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_dout,
  output logic                      rd_valid,
  output logic [1:0]                rd_id,
  output logic [DATA_W-1:0]         rd_data
);
  logic [1:0]        ptr;
  logic [1:0]        gnt_id;
  logic [1:0]        win;
  logic              found;
  logic [ADDR_W-1:0] win_addr;
  logic [N_REQ-1:0]  elig;
  int                j;
  logic [ROM_LAT-1:0] vpipe;
  logic [1:0]        idpipe [ROM_LAT];
  assign elig = req & ~gnt;
  // pick the first eligible requester searching upward from ptr+1 with wrap
  always_comb begin
    found    = 1'b0;
    win      = ptr;
    win_addr = rom_addr;
    j        = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!found && elig[j]) begin
        found    = 1'b1;
        win      = 2'(j);
        win_addr = addr[j*ADDR_W +: ADDR_W];
      end
    end
  end
  // register grant and ROM request, carry valid/ID alongside the ROM latency, capture response
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      ptr      <= 2'(N_REQ - 1);
      gnt_id   <= '0;
      vpipe    <= '0;
      for (int k = 0; k < ROM_LAT; k++) idpipe[k] <= '0;
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_data  <= '0;
    end else begin
      gnt      <= found ? N_REQ'(1) << win : '0;
      rom_en   <= found;
      rom_addr <= found ? win_addr : rom_addr;
      ptr      <= found ? win : ptr;
      gnt_id   <= found ? win : gnt_id;
      vpipe[0]  <= rom_en;
      idpipe[0] <= gnt_id;
      for (int k = 1; k < ROM_LAT; k++) begin
        vpipe[k]  <= vpipe[k-1];
        idpipe[k] <= idpipe[k-1];
      end
      rd_valid <= vpipe[ROM_LAT-1];
      rd_id    <= vpipe[ROM_LAT-1] ? idpipe[ROM_LAT-1] : rd_id;
      rd_data  <= vpipe[ROM_LAT-1] ? rom_dout : rd_data;
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed vectors with hand-computed expectations for the sprite ROM arbiter
module tb_sprite_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [27:0] addr = '0;
  logic [3:0]  gnt;
  logic        rom_en;
  logic [6:0]  rom_addr;
  logic [63:0] rom_dout = '0;
  logic        rd_valid;
  logic [1:0]  rd_id;
  logic [63:0] rd_data;
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  exp_gnt [6];

  sprite_rom_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // one-cycle ROM returning the address zero-extended
  always_ff @(posedge clk) if (rom_en) rom_dout <= {57'h0, rom_addr};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_rom_en", 64'(rom_en), 0);
    chk("rst_rom_addr", 64'(rom_addr), 0);
    chk("rst_rd_valid", 64'(rd_valid), 0);
    chk("rst_rd_id", 64'(rd_id), 0);
    chk("rst_rd_data", rd_data, 0);

    // all four requesting after reset: 0,1,2,3,0 with rom_en every cycle
    rst = 1'b0;
    addr = {7'h13, 7'h12, 7'h11, 7'h10};
    req = 4'b1111;
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("prio_gnt", 64'(gnt), 64'(exp_gnt[k]));
      chk("prio_rom_en", 64'(rom_en), 1);
      chk("prio_rom_addr", 64'(rom_addr), 64'(7'h10 + 7'(k % 4)));
      if (k >= 2) begin
        chk("prio_rd_valid", 64'(rd_valid), 1);
        chk("prio_rd_id", 64'(rd_id), 64'(k - 2));
        chk("prio_rd_data", rd_data, 64'(8'h10 + 8'(k - 2)));
      end
    end

    // single requester 2: granted every other cycle, response two cycles later
    do_reset;
    addr = {7'h00, 7'h21, 7'h00, 7'h00};
    req = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("single_gnt", 64'(gnt), (k % 2 == 0) ? 64'h4 : 64'h0);
      chk("single_rom_en", 64'(rom_en), (k % 2 == 0) ? 64'h1 : 64'h0);
      chk("single_rom_addr", 64'(rom_addr), 64'h21);
      chk("single_rd_valid", 64'(rd_valid), (k >= 2 && k % 2 == 0) ? 64'h1 : 64'h0);
      if (k >= 2) begin
        chk("single_rd_id", 64'(rd_id), 2);
        chk("single_rd_data", rd_data, 64'h21);
      end
    end

    // wrap-around from ptr=1 with req=1011: 3,0,1,3,0,1
    do_reset;
    req = 4'b0010;
    tick;
    chk("wrap_setup_gnt", 64'(gnt), 64'h2);
    req = 4'b1011;
    exp_gnt[0] = 4'b1000; exp_gnt[1] = 4'b0001; exp_gnt[2] = 4'b0010;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001; exp_gnt[5] = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("wrap_gnt", 64'(gnt), 64'(exp_gnt[k]));
    end

    // back-to-back grants to 0 then 1 return in order
    do_reset;
    addr = {7'h00, 7'h00, 7'h12, 7'h05};
    req = 4'b0011;
    tick;
    chk("b2b_gnt0", 64'(gnt), 64'h1);
    req = 4'b0010;
    tick;
    chk("b2b_gnt1", 64'(gnt), 64'h2);
    req = 4'b0000;
    tick;
    chk("b2b_v0", 64'(rd_valid), 1);
    chk("b2b_id0", 64'(rd_id), 0);
    chk("b2b_d0", rd_data, 64'h05);
    tick;
    chk("b2b_v1", 64'(rd_valid), 1);
    chk("b2b_id1", 64'(rd_id), 1);
    chk("b2b_d1", rd_data, 64'h12);
    tick;
    chk("b2b_idle_v", 64'(rd_valid), 0);
    chk("b2b_hold_id", 64'(rd_id), 1);
    chk("b2b_hold_d", rd_data, 64'h12);

    // reset while a read is in flight: no response ever appears
    do_reset;
    req = 4'b0001;
    tick;
    chk("rmf_gnt", 64'(gnt), 64'h1);
    req = 4'b0000;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rmf_gnt_zero", 64'(gnt), 0);
    chk("rmf_rom_en_zero", 64'(rom_en), 0);
    chk("rmf_rom_addr_zero", 64'(rom_addr), 0);
    chk("rmf_rd_valid_zero", 64'(rd_valid), 0);
    chk("rmf_rd_id_zero", 64'(rd_id), 0);
    chk("rmf_rd_data_zero", rd_data, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("rmf_rd_valid_after", 64'(rd_valid), 0);
    end

    // req[3] pulsed for one cycle while index 0 wins: index 3 is dropped
    do_reset;
    addr = {7'h33, 7'h00, 7'h00, 7'h05};
    req = 4'b1001;
    tick;
    req = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick;
      chk("wd_gnt", 64'(gnt), (k % 2 == 0) ? 64'h1 : 64'h0);
      chk("wd_rd_valid", 64'(rd_valid), (k >= 2 && k % 2 == 0) ? 64'h1 : 64'h0);
      if (k >= 2) chk("wd_rd_id", 64'(rd_id), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
